// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display path.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int DIG_W      = 2;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  typedef logic [DIG_W-1:0] dig_t;

  typedef struct packed {
    logic [1:0] tens;
    logic [3:0] ones;
  } dec_split_t;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

  // Input never exceeds 31, so a three-threshold compare replaces a divider.
  function automatic dec_split_t bin_to_dec(input logic [4:0] v);
    dec_split_t r;
    logic [4:0] tens_x10;
    logic [4:0] ones_full;
    if (v >= 5'd30)      r.tens = 2'd3;
    else if (v >= 5'd20) r.tens = 2'd2;
    else if (v >= 5'd10) r.tens = 2'd1;
    else                 r.tens = 2'd0;
    tens_x10  = 5'd10 * {3'b000, r.tens};
    ones_full = v - tens_x10;
    r.ones    = ones_full[3:0];
    return r;
  endfunction

endpackage

// File: rtl/sum_seg7_scan_if.sv
// Adder-result input and display-pin output bundle for sum_seg7_scan.
interface sum_seg7_scan_if;
  logic [4:0] q;
  logic       mode_dec;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output q, output mode_dec, input an, input seg, input dp);
  modport slave  (input q, input mode_dec, output an, output seg, output dp);
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder with blanking.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) seg_o = hex_glyph(nib_i);
  end

endmodule

// File: rtl/sum_seg7_scan.sv
// Scans a 4-digit common-anode display showing the adder result in hex or decimal.
// The result is snapshotted once per frame so a frame never mixes two values.
module sum_seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  sum_seg7_scan_if.slave  bus
);

  localparam int              CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam dig_t            DIG_LAST = dig_t'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  dig_t             dig_q, dig_d;
  logic [4:0]       snap_q, snap_d;
  logic             snap_mode_q, snap_mode_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             cnt_last;
  dec_split_t       dec;
  logic [3:0]       nib;
  logic             blank;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign dec      = bin_to_dec(snap_q);

  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    dig_d       = dig_q;
    snap_d      = snap_q;
    snap_mode_d = snap_mode_q;
    if (cnt_last) begin
      cnt_d = '0;
      dig_d = dig_q + dig_t'(1);
      // Load only as the last digit of a frame finishes.
      if (dig_q == DIG_LAST) begin
        snap_d      = bus.q;
        snap_mode_d = bus.mode_dec;
      end
    end
  end

  always_comb begin
    nib   = 4'h0;
    blank = 1'b1;
    dp_d  = 1'b1;
    an_d  = ~(4'b0001 << dig_q);
    if (!snap_mode_q) begin
      case (dig_q)
        2'd0: begin nib = snap_q[3:0];           blank = 1'b0; dp_d = 1'b0; end
        2'd1: begin nib = {3'b000, snap_q[4]};   blank = 1'b0; end
        default: ;
      endcase
    end else begin
      case (dig_q)
        2'd0: begin nib = dec.ones;              blank = 1'b0; end
        2'd1: begin nib = {2'b00, dec.tens};     blank = (dec.tens == 2'd0); end
        default: ;
      endcase
    end
  end

  hex_to_seg7 u_dec (
    .nib_i   (nib),
    .blank_i (blank),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      dig_q       <= '0;
      snap_q      <= '0;
      snap_mode_q <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      snap_q      <= snap_d;
      snap_mode_q <= snap_mode_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_sum_seg7_scan.sv
// Scoreboard bench for sum_seg7_scan with REFRESH_DIV=4 (16-cycle frame).
module tb_sum_seg7_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sum_seg7_scan_if bus ();

  sum_seg7_scan #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] sb[$];  // {an, seg, dp}

  int         m_cnt, m_dig;
  logic [4:0] m_snap;
  logic       m_mode;

  logic [3:0] obs_an [16];
  logic [6:0] obs_seg[16];
  logic       obs_dp [16];

  function automatic logic [6:0] ref_glyph(input int d);
    case (d)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [11:0] ref_out(input int dig, input logic [4:0] s, input logic md);
    logic [3:0] an;
    logic [6:0] sg;
    logic       dp;
    int         v;
    an = 4'b1111;
    an[dig] = 1'b0;
    sg = 7'h7F;
    dp = 1'b1;
    v  = int'(s);
    if (!md) begin
      if (dig == 0) begin sg = ref_glyph(v % 16); dp = 1'b0; end
      else if (dig == 1) sg = ref_glyph(v / 16);
    end else begin
      if (dig == 0) sg = ref_glyph(v % 10);
      else if (dig == 1 && v >= 10) sg = ref_glyph(v / 10);
    end
    return {an, sg, dp};
  endfunction

  // Advance one clock: predict the registered output from the pre-edge model state.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      sb.push_back({4'b1111, 7'h7F, 1'b1});
      m_cnt = 0; m_dig = 0; m_snap = 5'd0; m_mode = 1'b0;
    end else begin
      sb.push_back(ref_out(m_dig, m_snap, m_mode));
      if (m_cnt == 3) begin
        m_cnt = 0;
        if (m_dig == 3) begin
          m_snap = bus.q;
          m_mode = bus.mode_dec;
        end
        m_dig = (m_dig + 1) % 4;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input int chg_at, input logic [4:0] nq, input logic nm);
    logic [11:0] exp_v, got;
    for (int i = 0; i < 16; i++) begin
      if (i == chg_at) begin
        bus.q        = nq;
        bus.mode_dec = nm;
      end
      tick();
      got = {bus.an, bus.seg, bus.dp};
      obs_an[i]  = bus.an;
      obs_seg[i] = bus.seg;
      obs_dp[i]  = bus.dp;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty cycle %0d got %h want queued entry", i, got);
      end else begin
        exp_v = sb.pop_front();
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL sb_frame cycle %0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                   i, got[11:8], got[7:1], got[0], exp_v[11:8], exp_v[7:1], exp_v[0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [11:0] got, exp_v;
    rst = 1'b1;
    bus.q = 5'h00;
    bus.mode_dec = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      void'(sb.pop_front());
      got = {bus.an, bus.seg, bus.dp};
      n_checks++;
      if (got !== {4'b1111, 7'h7F, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_init got %h want %h", got, {4'b1111, 7'h7F, 1'b1});
      end
    end
    rst = 1'b0;
    bus.q = 5'h1B;
    for (int i = 0; i < 22; i++) begin
      tick();
      got = {bus.an, bus.seg, bus.dp};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL pre_reset_scan cycle %0d got %h want %h", i, got, exp_v);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      void'(sb.pop_front());
      got = {bus.an, bus.seg, bus.dp};
      n_checks++;
      if (got !== {4'b1111, 7'h7F, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_midscan got %h want %h", got, {4'b1111, 7'h7F, 1'b1});
      end
    end
    rst = 1'b0;
    run_frame(-1, 5'h00, 1'b0);
    n_checks++;
    if (obs_an[0] !== 4'b1110 || obs_seg[0] !== 7'b1000000 || obs_dp[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_digit got an=%b seg=%b dp=%b want an=1110 seg=1000000 dp=0",
               obs_an[0], obs_seg[0], obs_dp[0]);
    end
  endtask

  task automatic test_hex_0e();
    logic [3:0] want_an;
    bus.q = 5'h0E;
    bus.mode_dec = 1'b0;
    run_frame(-1, 5'h0E, 1'b0);
    for (int f = 0; f < 2; f++) begin
      run_frame(-1, 5'h0E, 1'b0);
      n_checks++;
      if (obs_seg[0] !== 7'b0000110 || obs_dp[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL hex0e_d0 got seg=%b dp=%b want seg=0000110 dp=0", obs_seg[0], obs_dp[0]);
      end
      n_checks++;
      if (obs_seg[4] !== 7'b1000000) begin
        n_fail++;
        $display("FAIL hex0e_d1 got %b want 1000000", obs_seg[4]);
      end
      n_checks++;
      if (obs_seg[8] !== 7'h7F || obs_seg[12] !== 7'h7F) begin
        n_fail++;
        $display("FAIL hex0e_blank got %b/%b want 1111111", obs_seg[8], obs_seg[12]);
      end
      for (int i = 0; i < 16; i++) begin
        want_an = 4'b1111;
        want_an[i / 4] = 1'b0;
        n_checks++;
        if (obs_an[i] !== want_an) begin
          n_fail++;
          $display("FAIL hex0e_an cycle %0d got %b want %b", i, obs_an[i], want_an);
        end
      end
    end
  endtask

  task automatic test_hex_13();
    bus.q = 5'h13;
    bus.mode_dec = 1'b0;
    run_frame(-1, 5'h13, 1'b0);
    run_frame(-1, 5'h13, 1'b0);
    n_checks++;
    if (obs_seg[0] !== 7'b0110000 || obs_seg[4] !== 7'b1111001) begin
      n_fail++;
      $display("FAIL hex13 got d0=%b d1=%b want d0=0110000 d1=1111001", obs_seg[0], obs_seg[4]);
    end
  endtask

  task automatic test_decimal();
    logic [4:0] qv[3]  = '{5'h13, 5'h1E, 5'h06};
    logic [6:0] w0[3]  = '{7'b0010000, 7'b1000000, 7'b0000010};
    logic [6:0] w1[3]  = '{7'b1111001, 7'b0110000, 7'h7F};
    for (int k = 0; k < 3; k++) begin
      bus.q = qv[k];
      bus.mode_dec = 1'b1;
      run_frame(-1, qv[k], 1'b1);
      run_frame(-1, qv[k], 1'b1);
      n_checks++;
      if (obs_seg[0] !== w0[k] || obs_seg[4] !== w1[k]) begin
        n_fail++;
        $display("FAIL dec_q%h got d0=%b d1=%b want d0=%b d1=%b",
                 qv[k], obs_seg[0], obs_seg[4], w0[k], w1[k]);
      end
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (obs_dp[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL dec_dp cycle %0d got %b want 1", i, obs_dp[i]);
        end
      end
    end
  endtask

  task automatic test_midframe();
    bus.q = 5'h06;
    bus.mode_dec = 1'b0;
    run_frame(-1, 5'h06, 1'b0);
    run_frame(5, 5'h0F, 1'b0);
    n_checks++;
    if (obs_seg[0] !== 7'b0000010) begin
      n_fail++;
      $display("FAIL mid_q_hold got %b want 0000010", obs_seg[0]);
    end
    run_frame(2, 5'h06, 1'b0);
    n_checks++;
    if (obs_seg[0] !== 7'b0001110 || obs_seg[3] !== 7'b0001110) begin
      n_fail++;
      $display("FAIL mid_q_new got %b/%b want 0001110", obs_seg[0], obs_seg[3]);
    end
    bus.q = 5'h0F;
    run_frame(-1, 5'h0F, 1'b0);
    run_frame(5, 5'h0F, 1'b1);
    n_checks++;
    if (obs_seg[0] !== 7'b0001110 || obs_dp[0] !== 1'b0 || obs_seg[6] !== 7'b1000000) begin
      n_fail++;
      $display("FAIL mid_mode_hold got d0=%b dp=%b d1=%b want d0=0001110 dp=0 d1=1000000",
               obs_seg[0], obs_dp[0], obs_seg[6]);
    end
    run_frame(-1, 5'h0F, 1'b1);
    n_checks++;
    if (obs_seg[0] !== 7'b0010010 || obs_seg[4] !== 7'b1111001 || obs_dp[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mode_new got d0=%b d1=%b dp=%b want d0=0010010 d1=1111001 dp=1",
               obs_seg[0], obs_seg[4], obs_dp[0]);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] want_an;
    bus.q = 5'h1F;
    for (int f = 0; f < 3; f++) begin
      run_frame(-1, 5'h1F, bus.mode_dec);
      for (int i = 0; i < 16; i++) begin
        want_an = 4'b1111;
        want_an[i / 4] = 1'b0;
        n_checks++;
        if (obs_an[i] !== want_an) begin
          n_fail++;
          $display("FAIL wrap_an frame %0d cycle %0d got %b want %b", f, i, obs_an[i], want_an);
        end
        n_checks++;
        if ($countones(~obs_an[i]) != 1) begin
          n_fail++;
          $display("FAIL wrap_onehot frame %0d cycle %0d got %b want one low bit", f, i, obs_an[i]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_cnt = 0; m_dig = 0; m_snap = 5'd0; m_mode = 1'b0;
    test_reset();
    test_hex_0e();
    test_hex_13();
    test_decimal();
    test_midframe();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
